// File: rtl/cpu_pkg.sv
// Shared definitions for the performance-counter unit: CSR map, counter
// indices and run/halt state encoding.
package cpu_pkg;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_STALL    = 12'hC03;
  localparam logic [11:0] CSR_STALLH   = 12'hC83;
  localparam logic [11:0] CSR_FLUSH    = 12'hC04;
  localparam logic [11:0] CSR_FLUSHH   = 12'hC84;

  localparam int NUM_CNT     = 4;
  localparam int IDX_CYCLE   = 0;
  localparam int IDX_INSTRET = 1;
  localparam int IDX_STALL   = 2;
  localparam int IDX_FLUSH   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } perf_state_t;

endpackage

// File: rtl/perf_counter_unit_if.sv
// CSR-style read port of the performance-counter unit.
interface perf_counter_unit_if;
  logic        csr_rd_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_valid;
  logic        csr_rd_err;

  modport master (
    output csr_rd_en, csr_addr,
    input  csr_rd_data, csr_rd_valid, csr_rd_err
  );

  modport slave (
    input  csr_rd_en, csr_addr,
    output csr_rd_data, csr_rd_valid, csr_rd_err
  );
endinterface

// File: rtl/perf_counter.sv
// CNT_W-bit wrapping event counter; synchronous clear beats increment.
module perf_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Cycle/instret/stall/flush counters gated by a run/halt FSM, with a
// registered CSR read port giving coherent 64-bit reads via shadows.
module perf_counter_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W     = 64,
  parameter bit HALT_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             clear,
  input  logic             retire,
  input  logic             stall,
  input  logic             flush,
  perf_counter_unit_if.slave csr,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret,
  output logic             running
);

  perf_state_t        state_q, state_d;
  logic               running_q;
  logic               count_en;
  logic [CNT_W-1:0]   cnt       [NUM_CNT];
  logic [63:0]        cnt_w     [NUM_CNT];
  logic [31:0]        shadow_hi_q [NUM_CNT];
  logic [NUM_CNT-1:0] capture;
  logic [31:0]        rd_data_d, rd_data_q;
  logic               rd_err_d, rd_err_q, rd_valid_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (halt)  state_d = HALTED;
        HALTED:  if (!HALT_HOLD && start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
    end
  end

  // The halt cycle itself is still a RUN cycle and is counted.
  assign count_en = (state_q == RUN);

  perf_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk(clk), .reset(reset), .en(count_en), .inc(1'b1),
    .clr(clear), .count(cnt[IDX_CYCLE])
  );
  perf_counter #(.CNT_W(CNT_W)) u_instret (
    .clk(clk), .reset(reset), .en(count_en), .inc(retire),
    .clr(clear), .count(cnt[IDX_INSTRET])
  );
  perf_counter #(.CNT_W(CNT_W)) u_stalls (
    .clk(clk), .reset(reset), .en(count_en), .inc(stall),
    .clr(clear), .count(cnt[IDX_STALL])
  );
  perf_counter #(.CNT_W(CNT_W)) u_flushes (
    .clk(clk), .reset(reset), .en(count_en), .inc(flush),
    .clr(clear), .count(cnt[IDX_FLUSH])
  );

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_w[i] = 64'(cnt[i]);
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    capture   = '0;
    if (csr.csr_rd_en) begin
      case (csr.csr_addr)
        CSR_CYCLE:    begin rd_data_d = cnt_w[IDX_CYCLE][31:0];   capture[IDX_CYCLE]   = 1'b1; end
        CSR_INSTRET:  begin rd_data_d = cnt_w[IDX_INSTRET][31:0]; capture[IDX_INSTRET] = 1'b1; end
        CSR_STALL:    begin rd_data_d = cnt_w[IDX_STALL][31:0];   capture[IDX_STALL]   = 1'b1; end
        CSR_FLUSH:    begin rd_data_d = cnt_w[IDX_FLUSH][31:0];   capture[IDX_FLUSH]   = 1'b1; end
        CSR_CYCLEH:   rd_data_d = shadow_hi_q[IDX_CYCLE];
        CSR_INSTRETH: rd_data_d = shadow_hi_q[IDX_INSTRET];
        CSR_STALLH:   rd_data_d = shadow_hi_q[IDX_STALL];
        CSR_FLUSHH:   rd_data_d = shadow_hi_q[IDX_FLUSH];
        default:      rd_err_d  = 1'b1;
      endcase
    end
  end

  // Only the upper half of a shadow is ever returned, so only it is kept.
  // NOTE: the shadow array is small register state that software observes, so it is reset explicitly rather than left unknown like a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_hi_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clear) begin
          shadow_hi_q[i] <= '0;
        end else if (capture[i]) begin
          shadow_hi_q[i] <= cnt_w[i][63:32];
        end
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= csr.csr_rd_en;
      rd_err_q   <= rd_err_d;
    end
  end

  assign csr.csr_rd_data  = rd_data_q;
  assign csr.csr_rd_valid = rd_valid_q;
  assign csr.csr_rd_err   = rd_err_q;
  assign cycles           = cnt[IDX_CYCLE];
  assign instret          = cnt[IDX_INSTRET];
  assign running          = running_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit: directed scenarios plus random
// traffic, all compared against an event-level reference model.
module tb_perf_counter_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, halt, clear, retire, stall, flush;
  logic [63:0] cycles, instret;
  logic        running;

  perf_counter_unit_if csr_if ();

  perf_counter_unit #(.CNT_W(64), .HALT_HOLD(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .clear(clear),
    .retire(retire), .stall(stall), .flush(flush), .csr(csr_if),
    .cycles(cycles), .instret(instret), .running(running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counters indexed cycle/instret/stall/flush.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;
  localparam bit M_HOLD = 1'b1;
  longint unsigned m_cnt [4];
  longint unsigned m_shd [4];
  int              m_state;
  int              bases [4] = '{'hC00, 'hC02, 'hC03, 'hC04};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0;
      m_shd[k] = 0;
    end
    m_state = M_IDLE;
  endtask

  task automatic model_edge(input bit st, hl, cl, rt, sv, fl, re, input logic [11:0] ad,
                            output logic [31:0] exp_data, output bit exp_err);
    int cap = -1;
    bit hit = 1'b0;
    exp_data = '0;
    exp_err  = 1'b0;
    if (re) begin
      for (int k = 0; k < 4; k++) begin
        if (int'(ad) == bases[k]) begin
          exp_data = m_cnt[k][31:0];
          cap = k;
          hit = 1'b1;
        end else if (int'(ad) == bases[k] + 'h80) begin
          exp_data = m_shd[k][63:32];
          hit = 1'b1;
        end
      end
      exp_err = !hit;
    end
    if (cl) begin
      model_reset();
    end else begin
      if (cap >= 0) m_shd[cap] = m_cnt[cap];
      if (m_state == M_RUN) begin
        m_cnt[0] += 1;
        m_cnt[1] += longint'(rt);
        m_cnt[2] += longint'(sv);
        m_cnt[3] += longint'(fl);
      end
      case (m_state)
        M_IDLE:   if (st) m_state = M_RUN;
        M_RUN:    if (hl) m_state = M_HALTED;
        M_HALTED: if (st && !M_HOLD) m_state = M_RUN;
        default:  m_state = M_IDLE;
      endcase
    end
  endtask

  task automatic step(input bit st, hl, cl, rt, sv, fl, re, input logic [11:0] ad);
    logic [31:0] ed;
    bit          ee;
    start = st; halt = hl; clear = cl; retire = rt; stall = sv; flush = fl;
    csr_if.csr_rd_en = re;
    csr_if.csr_addr  = ad;
    @(posedge clk);
    model_edge(st, hl, cl, rt, sv, fl, re, ad, ed, ee);
    #1;
    start = 0; halt = 0; clear = 0; retire = 0; stall = 0; flush = 0;
    csr_if.csr_rd_en = 0;
    csr_if.csr_addr  = '0;
    check("cycles", cycles, m_cnt[0]);
    check("instret", instret, m_cnt[1]);
    check("running", 64'(running), 64'(m_state == M_RUN));
    check("state", 64'(dut.state_q), 64'(m_state));
    check("rd_valid", 64'(csr_if.csr_rd_valid), 64'(re));
    check("rd_err", 64'(csr_if.csr_rd_err), 64'(ee));
    if (re) check("rd_data", 64'(csr_if.csr_rd_data), 64'(ed));
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 12'h000);
  endtask

  task automatic read_step(input logic [11:0] ad);
    step(0, 0, 0, 0, 0, 0, 1, ad);
  endtask

  initial begin
    logic [24:0] rmask;
    int          nset;
    int          pend_k;
    reset = 1'b1;
    start = 0; halt = 0; clear = 0; retire = 0; stall = 0; flush = 0;
    csr_if.csr_rd_en = 0;
    csr_if.csr_addr  = '0;
    model_reset();

    #15;
    check("reset_cycles", cycles, 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_running", 64'(running), 64'd0);
    check("reset_rd_data", 64'(csr_if.csr_rd_data), 64'd0);
    check("reset_rd_valid", 64'(csr_if.csr_rd_valid), 64'd0);
    check("reset_rd_err", 64'(csr_if.csr_rd_err), 64'd0);
    check("reset_state", 64'(dut.state_q), 64'(IDLE));
    #5 reset = 1'b0;

    // 25 RUN cycles, retire on 8 of them, halt on the last one.
    rmask = '0;
    nset  = 0;
    while (nset < 8) begin
      int b;
      b = int'($urandom_range(24, 0));
      if (!rmask[b]) begin
        rmask[b] = 1'b1;
        nset++;
      end
    end
    step(1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int i = 0; i < 25; i++) step(0, (i == 24), 0, rmask[i], 0, 0, 0, 12'h000);
    check("cpi_cycles", cycles, 64'd25);
    check("cpi_instret", instret, 64'd8);
    check("cpi_running", 64'(running), 64'd0);
    check("cpi_state", 64'(dut.state_q), 64'(HALTED));
    for (int i = 0; i < 100; i++)
      step(($urandom_range(3, 0) == 0), 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 12'h000);
    check("hold_cycles", cycles, 64'd25);
    check("hold_instret", instret, 64'd8);

    // Stall and flush counts through the CSR port.
    step(0, 0, 1, 0, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 1'($urandom), (i == 1 || i == 4 || i == 7), (i == 2 || i == 8), 0, 12'h000);
    step(0, 1, 0, 0, 0, 0, 0, 12'h000);
    read_step(CSR_STALL);
    check("stall_csr", 64'(csr_if.csr_rd_data), 64'd3);
    read_step(CSR_FLUSH);
    check("flush_csr", 64'(csr_if.csr_rd_data), 64'd2);
    idle_step();

    // Low/high coherent read across a 32-bit carry.
    step(0, 0, 1, 0, 0, 0, 0, 12'h000);
    force dut.u_cycles.cnt_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.u_cycles.cnt_q;
    m_cnt[0] = 64'h0000_0000_FFFF_FFFE;
    step(1, 0, 0, 0, 0, 0, 0, 12'h000);
    step(0, 0, 0, 0, 0, 0, 0, 12'h000);
    step(0, 0, 0, 0, 0, 0, 0, 12'h000);
    step(0, 1, 0, 0, 0, 0, 0, 12'h000);
    check("wrap_cycles", cycles, 64'h0000_0001_0000_0001);
    read_step(CSR_CYCLE);
    check("wrap_lo", 64'(csr_if.csr_rd_data), 64'd1);
    read_step(CSR_CYCLEH);
    check("wrap_hi", 64'(csr_if.csr_rd_data), 64'd1);

    // Unmapped address: zero data and a single-cycle error pulse.
    read_step(12'h123);
    check("unmapped_data", 64'(csr_if.csr_rd_data), 64'd0);
    check("unmapped_err", 64'(csr_if.csr_rd_err), 64'd1);
    idle_step();
    check("unmapped_err_gone", 64'(csr_if.csr_rd_err), 64'd0);

    // clear beats start while running; counting restarts from 1.
    step(0, 0, 1, 0, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 1, 0, 12'h000);
    step(1, 0, 1, 1, 1, 1, 0, 12'h000);
    check("clr_start_cycles", cycles, 64'd0);
    check("clr_start_instret", instret, 64'd0);
    check("clr_start_state", 64'(dut.state_q), 64'(IDLE));
    step(1, 0, 0, 0, 0, 0, 0, 12'h000);
    idle_step();
    check("restart_cycles", cycles, 64'd1);

    // Random traffic, including back-to-back low/high pairs.
    pend_k = -1;
    for (int i = 0; i < 400; i++) begin
      bit          re;
      logic [11:0] ad;
      re = 1'($urandom);
      ad = 12'(bases[$urandom_range(3, 0)] + (($urandom_range(1, 0) == 1) ? 'h80 : 0));
      if (pend_k >= 0) begin
        re = 1'b1;
        ad = 12'(bases[pend_k] + 'h80);
        pend_k = -1;
      end else if (re && $urandom_range(9, 0) == 0) begin
        ad = 12'($urandom);
      end else if (re && ad[7] == 1'b0 && $urandom_range(1, 0) == 1) begin
        for (int k = 0; k < 4; k++) if (int'(ad) == bases[k]) pend_k = k;
      end
      step(($urandom_range(7, 0) == 0), ($urandom_range(15, 0) == 0),
           ($urandom_range(39, 0) == 0), 1'($urandom), 1'($urandom), 1'($urandom), re, ad);
    end

    // Asynchronous reset pulse between edges while running.
    step(0, 0, 1, 0, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, 0, 12'h000);
    read_step(CSR_INSTRET);
    #2 reset = 1'b1;
    #1;
    check("async_cycles", cycles, 64'd0);
    check("async_instret", instret, 64'd0);
    check("async_running", 64'(running), 64'd0);
    check("async_rd_data", 64'(csr_if.csr_rd_data), 64'd0);
    check("async_rd_valid", 64'(csr_if.csr_rd_valid), 64'd0);
    check("async_state", 64'(dut.state_q), 64'(IDLE));
    check("async_stalls", dut.u_stalls.count, 64'd0);
    #2 reset = 1'b0;
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0, 12'h000);
    read_step(CSR_CYCLE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
